// File: rtl/aibio_pvtmon_scan_ctrl.sv
// PVT monitor scan sequencer: walks the enabled sensor channels in ascending order,
// settling, triggering and collecting one measurement (or timeout) per channel.
module aibio_pvtmon_scan_ctrl #(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vdd,
   input  logic             vss,
   input  logic             start,
   input  logic             stop,
   input  logic             continuous,
   input  logic [7:0]       ch_mask,
   input  logic             meas_done,
   input  logic [CNT_W-1:0] meas_val,
   output logic [2:0]       sel,
   output logic             meas_start,
   output logic             busy,
   output logic             result_valid,
   output logic [2:0]       result_ch,
   output logic [CNT_W-1:0] result_data,
   output logic             result_to,
   output logic             scan_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_TRIG   = 2'd2;
   localparam logic [1:0] S_WAIT   = 2'd3;

   localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   // Counter is cleared in TRIG, so the last WAIT cycle is TIMEOUT_CYC-1 cycles after TRIG.
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT_CYC - 2);

   logic [1:0]       r_state;
   logic [2:0]       r_sel;
   logic [7:0]       r_mask;
   logic             r_cont;
   logic [CW-1:0]    r_cnt;
   logic             r_result_valid;
   logic [2:0]       r_result_ch;
   logic [CNT_W-1:0] r_result_data;
   logic             r_result_to;
   logic             r_scan_done;

   logic [7:0]       w_above;
   logic             w_has_next;
   logic [2:0]       w_next_ch;
   logic [2:0]       w_first_new;
   logic [2:0]       w_first_lat;
   logic             w_timeout;
   logic             w_unused_supply;

   function automatic logic [2:0] f_lowest(input logic [7:0] m);
      f_lowest = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) f_lowest = 3'(i);
      end
   endfunction

   assign w_above         = r_mask & (8'hFE << r_sel);
   assign w_has_next      = |w_above;
   assign w_next_ch       = f_lowest(w_above);
   assign w_first_new     = f_lowest(ch_mask);
   assign w_first_lat     = f_lowest(r_mask);
   assign w_timeout       = (r_cnt == WAIT_LAST);
   assign w_unused_supply = vdd ^ vss;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_sel          <= 3'd0;
         r_mask         <= 8'd0;
         r_cont         <= 1'b0;
         r_cnt          <= '0;
         r_result_valid <= 1'b0;
         r_result_ch    <= 3'd0;
         r_result_data  <= '0;
         r_result_to    <= 1'b0;
         r_scan_done    <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_scan_done    <= 1'b0;
         if (stop) begin
            // Abort drops any in-flight result; sel keeps its last value.
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && (ch_mask != 8'd0)) begin
                     r_state <= S_SETTLE;
                     r_sel   <= w_first_new;
                     r_mask  <= ch_mask;
                     r_cont  <= continuous;
                     r_cnt   <= '0;
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == SETTLE_LAST) begin
                     r_state <= S_TRIG;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_TRIG: begin
                  r_state <= S_WAIT;
                  r_cnt   <= '0;
               end
               default: begin
                  if (meas_done || w_timeout) begin
                     r_result_valid <= 1'b1;
                     r_result_ch    <= r_sel;
                     r_result_data  <= meas_done ? meas_val : '0;
                     r_result_to    <= ~meas_done;
                     r_cnt          <= '0;
                     if (w_has_next) begin
                        r_state <= S_SETTLE;
                        r_sel   <= w_next_ch;
                     end else begin
                        r_scan_done <= 1'b1;
                        if (r_cont) begin
                           r_state <= S_SETTLE;
                           r_sel   <= w_first_lat;
                        end else begin
                           r_state <= S_IDLE;
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign sel          = r_sel;
   assign meas_start   = (r_state == S_TRIG);
   assign busy         = (r_state != S_IDLE);
   assign result_valid = r_result_valid;
   assign result_ch    = r_result_ch;
   assign result_data  = r_result_data;
   assign result_to    = r_result_to;
   assign scan_done    = r_scan_done;

endmodule

// File: tb/tb_aibio_pvtmon_scan_ctrl.sv
// Directed bench for the PVT scan sequencer; a negedge monitor checks every
// result pulse against a queue of expected results filled by the stimulus.
module tb_aibio_pvtmon_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst, vdd, vss, start, stop, continuous, meas_done;
   logic [7:0] ch_mask;
   logic [9:0] meas_val;
   logic [2:0] sel, result_ch;
   logic       meas_start, busy, result_valid, result_to, scan_done;
   logic [9:0] result_data;

   typedef struct {
      logic [2:0] ch;
      logic [9:0] data;
      logic       to;
      logic       sd;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   aibio_pvtmon_scan_ctrl #(.SETTLE_CYC(16), .TIMEOUT_CYC(1024), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .start(start), .stop(stop),
      .continuous(continuous), .ch_mask(ch_mask), .meas_done(meas_done),
      .meas_val(meas_val), .sel(sel), .meas_start(meas_start), .busy(busy),
      .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
      .result_to(result_to), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   always @(negedge clk) begin
      if (scan_done && !result_valid) chk("scan_done_without_result", 1, 0);
      if (result_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("t=%0t result ch=%0d data=0x%0h to=%0d sd=%0d", $time,
                     result_ch, result_data, result_to, scan_done);
            chk("result_ch", int'(result_ch), int'(e.ch));
            chk("result_data", int'(result_data), int'(e.data));
            chk("result_to", int'(result_to), int'(e.to));
            chk("result_scan_done", int'(scan_done), int'(e.sd));
         end
      end
   end

   task automatic wait_trig(output bit ok);
      int n = 0;
      while (!meas_start && n < 100) begin
         tick();
         n++;
      end
      ok = meas_start;
      chk("meas_start_seen", int'(meas_start), 1);
   endtask

   // Wait for TRIG, hold off dly cycles, then return a measurement.
   task automatic do_channel(input logic [2:0] ch, input logic [9:0] val, input int dly,
                             input logic sd);
      bit ok;
      exp_t e;
      wait_trig(ok);
      if (ok) begin
         chk("sel_at_trig", int'(sel), int'(ch));
         repeat (dly) tick();
         meas_done = 1'b1;
         meas_val  = val;
         e.ch = ch; e.data = val; e.to = 1'b0; e.sd = sd;
         exp_q.push_back(e);
         tick();
         meas_done = 1'b0;
         meas_val  = 10'd0;
      end
   endtask

   task automatic start_scan(input logic [7:0] m, input logic cont);
      ch_mask    = m;
      continuous = cont;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      ch_mask    = 8'd0;
      continuous = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      int   t_trig;
      int   n;
      exp_t e;
      rst = 1'b1; vdd = 1'b1; vss = 1'b0; start = 1'b0; stop = 1'b0;
      continuous = 1'b0; meas_done = 1'b0; ch_mask = 8'd0; meas_val = 10'd0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_sel", int'(sel), 0);
      chk("reset_meas_start", int'(meas_start), 0);
      chk("reset_result_valid", int'(result_valid), 0);
      chk("reset_result_data", int'(result_data), 0);
      chk("reset_scan_done", int'(scan_done), 0);

      // Single channel, exact cycle timing
      cyc = 0;
      start_scan(8'h01, 1'b0);
      chk("a_busy_c1", int'(busy), 1);
      chk("a_sel_c1", int'(sel), 0);
      wait_trig(ok);
      chk("a_trig_cycle", cyc, 17);
      while (cyc < 30) tick();
      meas_done = 1'b1; meas_val = 10'h155;
      e.ch = 3'd0; e.data = 10'h155; e.to = 1'b0; e.sd = 1'b1;
      exp_q.push_back(e);
      tick();
      meas_done = 1'b0;
      chk("a_result_valid_c31", int'(result_valid), 1);
      chk("a_scan_done_c31", int'(scan_done), 1);
      chk("a_busy_c31", int'(busy), 0);
      repeat (3) tick();

      // Sparse mask, one pass
      start_scan(8'hA4, 1'b0);
      chk("b_first_sel", int'(sel), 2);
      do_channel(3'd2, 10'h011, 3, 1'b0);
      chk("b_sel_after_2", int'(sel), 5);
      do_channel(3'd5, 10'h222, 5, 1'b0);
      chk("b_sel_after_5", int'(sel), 7);
      do_channel(3'd7, 10'h3FF, 1, 1'b1);
      repeat (2) tick();
      chk("b_idle", int'(busy), 0);

      // Continuous wrap, then stop mid-WAIT
      start_scan(8'h81, 1'b1);
      do_channel(3'd0, 10'h001, 2, 1'b0);
      do_channel(3'd7, 10'h007, 2, 1'b1);
      chk("c_wrap_sel", int'(sel), 0);
      chk("c_wrap_busy", int'(busy), 1);
      do_channel(3'd0, 10'h100, 4, 1'b0);
      do_channel(3'd7, 10'h107, 4, 1'b1);
      wait_trig(ok);
      repeat (3) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("c_stop_busy", int'(busy), 0);
      chk("c_stop_sel_held", int'(sel), 0);
      meas_done = 1'b1; meas_val = 10'h0AB;
      tick();
      meas_done = 1'b0;
      chk("c_stop_no_result", int'(result_valid), 0);
      repeat (3) tick();

      // stop and start together in IDLE
      stop = 1'b1;
      start_scan(8'h01, 1'b0);
      stop = 1'b0;
      chk("stop_beats_start", int'(busy), 0);

      // Timeout on ch4, then meas_done exactly on the timeout cycle of ch5
      start_scan(8'h30, 1'b0);
      wait_trig(ok);
      chk("d_sel_ch4", int'(sel), 4);
      t_trig = cyc;
      e.ch = 3'd4; e.data = 10'd0; e.to = 1'b1; e.sd = 1'b0;
      exp_q.push_back(e);
      n = 0;
      while (!result_valid && n < 1100) begin
         tick();
         n++;
      end
      chk("d_timeout_latency", cyc - t_trig, 1024);
      do_channel(3'd5, 10'h2AA, 1023, 1'b1);
      repeat (2) tick();
      chk("d_idle", int'(busy), 0);

      // Empty mask is ignored
      start_scan(8'h00, 1'b0);
      repeat (2) tick();
      chk("e_mask0_busy", int'(busy), 0);

      // Spurious meas_done in SETTLE, then a normal result
      start_scan(8'h02, 1'b0);
      tick();
      meas_done = 1'b1; meas_val = 10'h3C3;
      tick();
      meas_done = 1'b0;
      chk("f_spurious_no_result", int'(result_valid), 0);
      do_channel(3'd1, 10'h0F0, 2, 1'b1);
      repeat (2) tick();

      // Reset during SETTLE clears every output
      start_scan(8'h40, 1'b0);
      repeat (4) tick();
      chk("g_in_settle", int'(busy), 1);
      rst = 1'b1;
      tick();
      chk("g_rst_sel", int'(sel), 0);
      chk("g_rst_busy", int'(busy), 0);
      chk("g_rst_meas_start", int'(meas_start), 0);
      chk("g_rst_result_valid", int'(result_valid), 0);
      chk("g_rst_result_ch", int'(result_ch), 0);
      chk("g_rst_result_data", int'(result_data), 0);
      chk("g_rst_result_to", int'(result_to), 0);
      chk("g_rst_scan_done", int'(scan_done), 0);
      rst = 1'b0;
      repeat (3) tick();

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
